uart_tx_sched: RTL and testbench

//  Schedules the shared UART transmit line (txd) between NUM_REQ byte requesters.

---
 rtl/uart_tx_sched.sv | 186 ++++++++++++++++++
 tb/tb_uart_tx_sched.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that serialises one requester's byte at a time onto txd.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_sched #(
    parameter int NUM_REQ      = 2,
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    localparam int GID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          cts_n,
    output logic                          txd,
    output logic                          busy,
    output logic [GID_W-1:0]              grant_id,
    output logic                          frame_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        cyc_cnt_reg, cyc_cnt_next;
    logic [BIT_W-1:0]        bit_cnt_reg, bit_cnt_next;
    logic [DATA_WIDTH-1:0]   shift_reg, shift_next;
    logic [GID_W-1:0]        grant_id_reg, grant_id_next;
    logic [GID_W-1:0]        rr_ptr_reg, rr_ptr_next;
`ifdef UART_TX_PARITY_EN
    logic                    parity_reg, parity_next;
`endif

    logic [DATA_WIDTH-1:0]   req_bytes [NUM_REQ];
    logic                    pick_found;
    logic [GID_W-1:0]        pick_idx;
    logic [GID_W-1:0]        cand_idx;
    int                      cand;
    logic                    accept;
    logic                    bit_end;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_bytes[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // First valid requester strictly after the last winner, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(rr_ptr_reg) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            cand_idx = GID_W'(cand);
            if (!pick_found && req_valid[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // Flow control is only consulted here, so a frame already started always completes.
    assign accept  = reset && !cts_n && pick_found && (state_reg == IDLE);
    assign bit_end = (cyc_cnt_reg == CNT_LAST);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg    <= IDLE;
            cyc_cnt_reg  <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            grant_id_reg <= '0;
            rr_ptr_reg   <= GID_W'(NUM_REQ - 1);
`ifdef UART_TX_PARITY_EN
            parity_reg   <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            cyc_cnt_reg  <= cyc_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            grant_id_reg <= grant_id_next;
            rr_ptr_reg   <= rr_ptr_next;
`ifdef UART_TX_PARITY_EN
            parity_reg   <= parity_next;
`endif
        end
    end

    always_comb begin
        state_next    = state_reg;
        cyc_cnt_next  = cyc_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        grant_id_next = grant_id_reg;
        rr_ptr_next   = rr_ptr_reg;
`ifdef UART_TX_PARITY_EN
        parity_next   = parity_reg;
`endif
        if (state_reg != IDLE) begin
            cyc_cnt_next = bit_end ? '0 : cyc_cnt_reg + 1'b1;
        end
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next    = START;
                    cyc_cnt_next  = '0;
                    bit_cnt_next  = '0;
                    shift_next    = req_bytes[pick_idx];
                    grant_id_next = pick_idx;
                    rr_ptr_next   = pick_idx;
`ifdef UART_TX_PARITY_EN
                    parity_next   = ^req_bytes[pick_idx];
`endif
                end
            end
            START: begin
                if (bit_end) state_next = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_next = shift_reg >> 1;
                    if (bit_cnt_reg == BIT_LAST) begin
                        bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
                        state_next   = PARITY;
`else
                        state_next   = STOP;
`endif
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) state_next = STOP;
            end
`endif
            STOP: begin
                if (bit_end) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready  = '0;
        txd        = 1'b1;
        busy       = (state_reg != IDLE);
        grant_id   = grant_id_reg;
        frame_done = 1'b0;
        if (accept) req_ready[pick_idx] = 1'b1;
        case (state_reg)
            START:  txd = 1'b0;
            DATA:   txd = shift_reg[0];
`ifdef UART_TX_PARITY_EN
            PARITY: txd = parity_reg;
`endif
            STOP: begin
                txd        = 1'b1;
                frame_done = bit_end;
            end
            default: txd = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: reset, round robin, single requester, flow control,
// reset mid-frame and (with UART_TX_PARITY_EN) the parity bit.
module tb_uart_tx_sched;

    localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_CYC = NBITS * CPB;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_ready;
    logic        cts_n;
    logic        txd;
    logic        busy;
    logic [0:0]  grant_id;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    uart_tx_sched #(.NUM_REQ(2), .DATA_WIDTH(8), .CLKS_PER_BIT(CPB)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .cts_n      (cts_n),
        .txd        (txd),
        .busy       (busy),
        .grant_id   (grant_id),
        .frame_done (frame_done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bit b of the result is the txd level during bit period b of the frame; p is hand-computed.
    function automatic logic [10:0] frame(input logic [7:0] d, input logic p);
`ifdef UART_TX_PARITY_EN
        return {1'b1, p, d, 1'b0};
`else
        return {1'b0, 1'b1, d, 1'b0};
`endif
    endfunction

    // Entered at a negedge in IDLE with inputs set; the accept happens on the next posedge.
    task automatic run_frame(input string tag, input int exp_gid, input logic [10:0] exp_bits,
                             input int cts_raise_k);
        int done_at;
        int done_cnt;
        #1;
        check({tag, ".ready"}, 32'(req_ready), 32'(1 << exp_gid));
        done_at  = -1;
        done_cnt = 0;
        for (int k = 1; k <= FRAME_CYC; k++) begin
            @(negedge clock);
            if ((k - 1) % CPB == CPB / 2)
                check($sformatf("%s.bit%0d", tag, (k - 1) / CPB), 32'(txd),
                      32'(exp_bits[(k - 1) / CPB]));
            if (frame_done) begin
                done_cnt++;
                done_at = k;
            end
            if (k == 1) begin
                check({tag, ".busy"}, 32'(busy), 32'd1);
                check({tag, ".gid"}, 32'(grant_id), 32'(exp_gid));
            end
            if (k == cts_raise_k) cts_n = 1'b1;
        end
        check({tag, ".done_cnt"}, 32'(done_cnt), 32'd1);
        check({tag, ".done_at"}, 32'(done_at), 32'(FRAME_CYC));
        @(negedge clock);
        check({tag, ".idle"}, 32'(busy), 32'd0);
        check({tag, ".gid_hold"}, 32'(grant_id), 32'(exp_gid));
        $display("frame %s: grant=%0d bits=%03h done_at=%0d", tag, grant_id, exp_bits, done_at);
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = 2'b11;
        req_data  = {8'h3C, 8'hA5};
        cts_n     = 1'b0;

        // T1: reset held three cycles with both requesters valid
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("t1.txd", 32'(txd), 32'd1);
            check("t1.busy", 32'(busy), 32'd0);
            check("t1.ready", 32'(req_ready), 32'd0);
            check("t1.done", 32'(frame_done), 32'd0);
            check("t1.gid", 32'(grant_id), 32'd0);
        end
        $display("reset: held 3 cycles");
        reset = 1'b1;

        // T3: round robin with both valid, grant order 0,1,0
        run_frame("t3a", 0, frame(8'hA5, 1'b0), 0);
        run_frame("t3b", 1, frame(8'h3C, 1'b0), 0);
        run_frame("t3c", 0, frame(8'hA5, 1'b0), 0);

        // T2: single requester 0, A5 -> 0,1,0,1,0,0,1,0,1,1
        req_valid = 2'b01;
        run_frame("t2", 0, frame(8'hA5, 1'b0), 0);

        // single requester 1 granted twice in a row
        req_valid = 2'b10;
        run_frame("single1a", 1, frame(8'h3C, 1'b0), 0);
        run_frame("single1b", 1, frame(8'h3C, 1'b0), 0);

        // T4: flow control blocks, then release; raise cts_n mid-DATA
        cts_n     = 1'b1;
        req_valid = 2'b01;
        for (int i = 0; i < 4; i++) begin
            repeat (5) @(negedge clock);
            check("t4.blocked", 32'(req_ready), 32'd0);
            check("t4.busy", 32'(busy), 32'd0);
        end
        $display("flow: blocked 20 cycles with cts_n high");
        cts_n = 1'b0;
        run_frame("t4", 0, frame(8'hA5, 1'b0), 50);
        repeat (3) @(negedge clock);
        check("t4.post_block", 32'(req_ready), 32'd0);
        check("t4.post_txd", 32'(txd), 32'd1);
        cts_n = 1'b0;

        // T5: reset during DATA bit 3 of requester 1's frame
        req_valid = 2'b11;
        #1;
        check("t5.ready", 32'(req_ready), 32'b10);
        for (int k = 1; k <= 73; k++) begin
            @(negedge clock);
            if (frame_done) check("t5.early_done", 32'(frame_done), 32'd0);
        end
        check("t5.bit3", 32'(txd), 32'd1);
        reset = 1'b0;
        @(negedge clock);
        check("t5.txd", 32'(txd), 32'd1);
        check("t5.busy", 32'(busy), 32'd0);
        check("t5.done", 32'(frame_done), 32'd0);
        check("t5.ready_rst", 32'(req_ready), 32'd0);
        $display("reset: aborted frame in DATA bit 3");
        reset = 1'b1;
        run_frame("t5", 0, frame(8'hA5, 1'b0), 0);

`ifdef UART_TX_PARITY_EN
        // T6: 07 has three ones -> parity 1; 03 has two -> parity 0
        req_valid = 2'b01;
        req_data  = {8'h3C, 8'h07};
        run_frame("t6a", 0, frame(8'h07, 1'b1), 0);
        req_data  = {8'h3C, 8'h03};
        run_frame("t6b", 0, frame(8'h03, 1'b0), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
